// File: rtl/indirect_mem_ctrl_pkg.sv
// Shared types for the LC-3b MEM-stage indirect (LDI/STI) sequencer.
// Provides the word type, the sequencer state encoding and an alignment helper.
package indirect_mem_ctrl_pkg;

    typedef logic [15:0] lc3b_word;

    typedef enum logic [1:0] {
        IND_IDLE  = 2'd0,
        IND_GAP   = 2'd1,
        IND_FINAL = 2'd2
    } ind_state_t;

    localparam logic [1:0] BYTE_EN_WORD = 2'b11;

    // Memory is word-addressed for these accesses, so bit 0 is always dropped.
    function automatic lc3b_word word_align(input lc3b_word addr);
        return {addr[15:1], 1'b0};
    endfunction

endpackage

// File: rtl/indirect_mem_ctrl_if.sv
// Data-memory port used by the indirect sequencer (master) and the memory (slave).
interface indirect_mem_ctrl_if;
    import indirect_mem_ctrl_pkg::*;

    logic       mem_read;
    logic       mem_write;
    lc3b_word   mem_address;
    lc3b_word   mem_wdata;
    logic [1:0] mem_byte_enable;
    logic       mem_resp;
    lc3b_word   mem_rdata;

    modport master (
        output mem_read, mem_write, mem_address, mem_wdata, mem_byte_enable,
        input  mem_resp, mem_rdata
    );

    modport slave (
        input  mem_read, mem_write, mem_address, mem_wdata, mem_byte_enable,
        output mem_resp, mem_rdata
    );

endinterface

// File: rtl/indirect_mem_ctrl.sv
// MEM-stage sequencer for LDI/STI: reads the pointer, idles GAP_CYCLES cycles,
// then performs the final read or write through the pointer.
module indirect_mem_ctrl
    import indirect_mem_ctrl_pkg::*;
#(
    parameter int GAP_CYCLES = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                run,
    input  logic                valid,
    input  logic                is_ldi,
    input  logic                is_sti,
    input  lc3b_word            ea,
    input  lc3b_word            sti_data,
    indirect_mem_ctrl_if.master mem,
    output logic                ldi_sti,
    output logic                ldi_sti_state,
    output lc3b_word            ldi_data
);

    localparam logic [1:0] GAP_LOAD = 2'(GAP_CYCLES - 1);

    ind_state_t state, state_next;
    lc3b_word   ptr, ptr_next;
    logic [1:0] gap_cnt, gap_next;
    logic       op_is_write;

    assign ldi_sti     = valid & (is_ldi | is_sti);
    assign op_is_write = is_sti & ~is_ldi;
    assign ldi_data    = mem.mem_rdata;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IND_IDLE;
            ptr     <= '0;
            gap_cnt <= '0;
        end else begin
            state   <= state_next;
            ptr     <= ptr_next;
            gap_cnt <= gap_next;
        end
    end

    // Requests are suppressed during reset so an abandoned access simply disappears.
    always_comb begin
        state_next           = state;
        ptr_next             = ptr;
        gap_next             = gap_cnt;
        mem.mem_read         = 1'b0;
        mem.mem_write        = 1'b0;
        mem.mem_address      = '0;
        mem.mem_wdata        = '0;
        mem.mem_byte_enable  = 2'b00;
        ldi_sti_state        = 1'b0;

        if (!reset) begin
            unique case (state)
                IND_IDLE: begin
                    if (ldi_sti) begin
                        mem.mem_read        = 1'b1;
                        mem.mem_address     = word_align(ea);
                        mem.mem_byte_enable = BYTE_EN_WORD;
                        if (mem.mem_resp) begin
                            ptr_next   = mem.mem_rdata;
                            gap_next   = GAP_LOAD;
                            state_next = IND_GAP;
                        end
                    end
                end
                IND_GAP: begin
                    if (!ldi_sti) begin
                        state_next = IND_IDLE;
                    end else if (gap_cnt == 2'd0) begin
                        state_next = IND_FINAL;
                    end else begin
                        gap_next = gap_cnt - 2'd1;
                    end
                end
                IND_FINAL: begin
                    // A response seen while the pipeline is frozen is repeated later; the access is idempotent.
                    if (!ldi_sti) begin
                        state_next = IND_IDLE;
                    end else begin
                        ldi_sti_state       = 1'b1;
                        mem.mem_address     = word_align(ptr);
                        mem.mem_byte_enable = BYTE_EN_WORD;
                        if (op_is_write) begin
                            mem.mem_write = 1'b1;
                            mem.mem_wdata = sti_data;
                        end else begin
                            mem.mem_read = 1'b1;
                        end
                        if (mem.mem_resp && run) begin
                            state_next = IND_IDLE;
                        end
                    end
                end
                default: state_next = IND_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_indirect_mem_ctrl.sv
// Self-checking bench for indirect_mem_ctrl: per-cycle vector tables, latency
// sequences, and a scoreboard of expected final accesses.
module tb_indirect_mem_ctrl;
    import indirect_mem_ctrl_pkg::*;

    typedef struct {
        logic     rst, run, valid, ldi, sti;
        lc3b_word ea, sdata;
        logic     push;
        logic     e_rd, e_wr;
        lc3b_word e_addr, e_wdata;
        logic     e_ls, e_lss;
    } vec_t;

    typedef struct {
        logic     wr;
        lc3b_word addr, data;
    } sb_t;

    logic     clk, reset, run, valid, is_ldi, is_sti;
    lc3b_word ea, sti_data, ldi_data;
    logic     ldi_sti, ldi_sti_state;

    int tests = 0;
    int fails = 0;
    int lat = 1;
    int wait_cnt = 0;

    lc3b_word memory [0:32767];
    vec_t     vecs [$];
    sb_t      sb_q [$];

    indirect_mem_ctrl_if mif ();

    indirect_mem_ctrl #(.GAP_CYCLES(1)) dut (
        .clk           (clk),
        .reset         (reset),
        .run           (run),
        .valid         (valid),
        .is_ldi        (is_ldi),
        .is_sti        (is_sti),
        .ea            (ea),
        .sti_data      (sti_data),
        .mem           (mif.master),
        .ldi_sti       (ldi_sti),
        .ldi_sti_state (ldi_sti_state),
        .ldi_data      (ldi_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: response arrives after lat cycles of a held request.
    always_comb begin
        mif.mem_resp  = (mif.mem_read | mif.mem_write) && (wait_cnt >= lat - 1);
        mif.mem_rdata = memory[mif.mem_address[15:1]];
    end

    always @(posedge clk) begin
        if (!(mif.mem_read | mif.mem_write) || mif.mem_resp)
            wait_cnt <= 0;
        else
            wait_cnt <= wait_cnt + 1;
    end

    task automatic checkVal(input string name, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic sb_t model(input logic ldi, input lc3b_word a, input lc3b_word sdata);
        sb_t e;
        lc3b_word p;
        p      = memory[a[15:1]];
        e.wr   = ~ldi;
        e.addr = {p[15:1], 1'b0};
        e.data = ldi ? memory[p[15:1]] : sdata;
        return e;
    endfunction

    // Scoreboard: compare each completed final access against the queued expectation.
    always @(negedge clk) begin
        if (!reset && ldi_sti_state && mif.mem_resp && run) begin
            if (sb_q.size() == 0) begin
                checkVal("sb_unexpected_completion", 16'd1, 16'd0);
            end else begin
                sb_t e;
                e = sb_q.pop_front();
                checkVal("sb_is_write", {15'd0, mif.mem_write}, {15'd0, e.wr});
                checkVal("sb_addr", mif.mem_address, e.addr);
                checkVal("sb_be", {14'd0, mif.mem_byte_enable}, 16'h0003);
                if (e.wr) checkVal("sb_wdata", mif.mem_wdata, e.data);
                else      checkVal("sb_ldi_data", ldi_data, e.data);
            end
        end
    end

    function automatic vec_t mk(input logic rst, input logic rn, input logic vl, input logic ldi,
                                input logic sti, input lc3b_word a, input lc3b_word sd,
                                input logic push, input logic erd, input logic ewr,
                                input lc3b_word eaddr, input lc3b_word ewd,
                                input logic els, input logic elss);
        vec_t v;
        v.rst = rst; v.run = rn; v.valid = vl; v.ldi = ldi; v.sti = sti;
        v.ea = a; v.sdata = sd; v.push = push;
        v.e_rd = erd; v.e_wr = ewr; v.e_addr = eaddr; v.e_wdata = ewd;
        v.e_ls = els; v.e_lss = elss;
        return v;
    endfunction

    task automatic applyStimulus(input vec_t v);
        reset    = v.rst;
        run      = v.run;
        valid    = v.valid;
        is_ldi   = v.ldi;
        is_sti   = v.sti;
        ea       = v.ea;
        sti_data = v.sdata;
        if (v.push) sb_q.push_back(model(v.ldi && !v.sti ? 1'b1 : v.ldi, v.ea, v.sdata));
    endtask

    task automatic checkOutput(input string tag, input int i, input vec_t v);
        logic [1:0] ebe;
        ebe = (v.e_rd | v.e_wr) ? 2'b11 : 2'b00;
        checkVal($sformatf("%s[%0d].read", tag, i), {15'd0, mif.mem_read}, {15'd0, v.e_rd});
        checkVal($sformatf("%s[%0d].write", tag, i), {15'd0, mif.mem_write}, {15'd0, v.e_wr});
        checkVal($sformatf("%s[%0d].addr", tag, i), mif.mem_address, v.e_addr);
        checkVal($sformatf("%s[%0d].wdata", tag, i), mif.mem_wdata, v.e_wdata);
        checkVal($sformatf("%s[%0d].be", tag, i), {14'd0, mif.mem_byte_enable}, {14'd0, ebe});
        checkVal($sformatf("%s[%0d].ldi_sti", tag, i), {15'd0, ldi_sti}, {15'd0, v.e_ls});
        checkVal($sformatf("%s[%0d].ldi_sti_state", tag, i), {15'd0, ldi_sti_state}, {15'd0, v.e_lss});
    endtask

    task automatic runTable(input string tag);
        for (int i = 0; i < vecs.size(); i++) begin
            @(posedge clk); #1;
            applyStimulus(vecs[i]);
            @(negedge clk);
            checkOutput(tag, i, vecs[i]);
        end
        vecs.delete();
    endtask

    // Runs one indirect op with run=1 and buckets its MEM cycles by phase.
    task automatic runIndirect(input logic ldi, input lc3b_word a, input lc3b_word sd,
                               output int ptr_c, output int gap_c, output int fin_c,
                               output int wr_c);
        logic done;
        ptr_c = 0; gap_c = 0; fin_c = 0; wr_c = 0; done = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0; run = 1'b1; valid = 1'b1;
        is_ldi = ldi; is_sti = ~ldi; ea = a; sti_data = sd;
        sb_q.push_back(model(ldi, a, sd));
        for (int c = 0; c < 50 && !done; c++) begin
            @(negedge clk);
            if (mif.mem_write) wr_c++;
            if (ldi_sti_state)     fin_c++;
            else if (mif.mem_read) ptr_c++;
            else                   gap_c++;
            if (ldi_sti_state && mif.mem_resp && run) done = 1'b1;
            else begin @(posedge clk); #1; end
        end
        if (!done) checkVal("run_indirect_timeout", 16'd1, 16'd0);
        @(posedge clk); #1;
        valid = 1'b0; is_ldi = 1'b0; is_sti = 1'b0;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit, got timeout, expected completion");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int p, g, f, w;
        for (int i = 0; i < 32768; i++) memory[i] = 16'h0000;
        memory[15'h1800] = 16'h4000;
        memory[15'h2000] = 16'hBEEF;
        memory[15'h1880] = 16'h5002;

        reset = 1'b1; run = 1'b1; valid = 1'b0; is_ldi = 1'b0; is_sti = 1'b0;
        ea = '0; sti_data = '0;

        // Reset holds requests off even with an LDI presented.
        vecs.push_back(mk(1,1,1,1,0,16'h3001,0,0, 0,0,16'h0000,0, 1,0));
        vecs.push_back(mk(1,1,1,1,0,16'h3001,0,0, 0,0,16'h0000,0, 1,0));
        vecs.push_back(mk(0,1,0,0,0,16'h0000,0,0, 0,0,16'h0000,0, 0,0));
        runTable("reset");

        // ADD, LDI, STI back-to-back, then a flush in FINAL and a fresh LDI.
        vecs.push_back(mk(0,1,1,0,0,16'h3001,0,0,      0,0,16'h0000,16'h0000, 0,0));
        vecs.push_back(mk(0,1,1,1,0,16'h3001,0,1,      1,0,16'h3000,16'h0000, 1,0));
        vecs.push_back(mk(0,1,1,1,0,16'h3001,0,0,      0,0,16'h0000,16'h0000, 1,0));
        vecs.push_back(mk(0,1,1,1,0,16'h3001,0,0,      1,0,16'h4000,16'h0000, 1,1));
        vecs.push_back(mk(0,1,1,0,1,16'h3100,16'h1234,1, 1,0,16'h3100,16'h0000, 1,0));
        vecs.push_back(mk(0,1,1,0,1,16'h3100,16'h1234,0, 0,0,16'h0000,16'h0000, 1,0));
        vecs.push_back(mk(0,1,1,0,1,16'h3100,16'h1234,0, 0,1,16'h5002,16'h1234, 1,1));
        vecs.push_back(mk(0,1,1,1,0,16'h3001,0,0,      1,0,16'h3000,16'h0000, 1,0));
        vecs.push_back(mk(0,1,1,1,0,16'h3001,0,0,      0,0,16'h0000,16'h0000, 1,0));
        vecs.push_back(mk(0,1,0,0,0,16'h3001,0,0,      0,0,16'h0000,16'h0000, 0,0));
        vecs.push_back(mk(0,1,1,1,0,16'h3001,0,1,      1,0,16'h3000,16'h0000, 1,0));
        vecs.push_back(mk(0,1,1,1,0,16'h3001,0,0,      0,0,16'h0000,16'h0000, 1,0));
        vecs.push_back(mk(0,1,1,1,0,16'h3001,0,0,      1,0,16'h4000,16'h0000, 1,1));
        vecs.push_back(mk(0,1,0,0,0,16'h0000,0,0,      0,0,16'h0000,16'h0000, 0,0));
        runTable("b2b");

        // FINAL sees mem_resp with run=0 twice; the request is held until run=1.
        vecs.push_back(mk(0,1,1,1,0,16'h3001,0,1, 1,0,16'h3000,0, 1,0));
        vecs.push_back(mk(0,1,1,1,0,16'h3001,0,0, 0,0,16'h0000,0, 1,0));
        vecs.push_back(mk(0,0,1,1,0,16'h3001,0,0, 1,0,16'h4000,0, 1,1));
        vecs.push_back(mk(0,0,1,1,0,16'h3001,0,0, 1,0,16'h4000,0, 1,1));
        vecs.push_back(mk(0,1,1,1,0,16'h3001,0,0, 1,0,16'h4000,0, 1,1));
        vecs.push_back(mk(0,1,0,0,0,16'h0000,0,0, 0,0,16'h0000,0, 0,0));
        runTable("stall");

        // Reset in GAP abandons the op; the next cycle is a pointer read again.
        vecs.push_back(mk(0,1,1,1,0,16'h3001,0,0, 1,0,16'h3000,0, 1,0));
        vecs.push_back(mk(1,1,1,1,0,16'h3001,0,0, 0,0,16'h0000,0, 1,0));
        vecs.push_back(mk(0,1,1,1,0,16'h3001,0,1, 1,0,16'h3000,0, 1,0));
        vecs.push_back(mk(0,1,1,1,0,16'h3001,0,0, 0,0,16'h0000,0, 1,0));
        vecs.push_back(mk(0,1,1,1,0,16'h3001,0,0, 1,0,16'h4000,0, 1,1));
        vecs.push_back(mk(0,1,0,0,0,16'h0000,0,0, 0,0,16'h0000,0, 0,0));
        runTable("rst_gap");

        // STI through pointer 5002: exactly one write cycle, 3 MEM cycles.
        memory[15'h1800] = 16'h5002;
        runIndirect(1'b0, 16'h3000, 16'h1234, p, g, f, w);
        checkVal("sti_ptr_cycles", 16'(p), 16'd1);
        checkVal("sti_gap_cycles", 16'(g), 16'd1);
        checkVal("sti_final_cycles", 16'(f), 16'd1);
        checkVal("sti_write_cycles", 16'(w), 16'd1);
        memory[15'h1800] = 16'h4000;

        // Four-cycle memory: pointer read and FINAL each held 4 cycles.
        lat = 4;
        runIndirect(1'b1, 16'h3001, 16'h0000, p, g, f, w);
        checkVal("lat4_ptr_cycles", 16'(p), 16'd4);
        checkVal("lat4_gap_cycles", 16'(g), 16'd1);
        checkVal("lat4_final_cycles", 16'(f), 16'd4);
        checkVal("lat4_write_cycles", 16'(w), 16'd0);
        lat = 1;

        @(posedge clk); #1;
        @(negedge clk);
        checkVal("sb_drained", 16'(sb_q.size()), 16'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/indirect_mem_ctrl.md
Name: indirect_mem_ctrl

Overview:
- MEM-stage sequencer for LC-3b LDI/STI. Each of these instructions needs two memory accesses; this block performs both.
- Access 1 reads the pointer at the effective address. Access 2 reads (LDI) or writes (STI) the word at that pointer.
- Drives the ldi_sti / ldi_sti_state pair consumed by the pipeline freeze logic. The data-port mux in MEM selects this block's request whenever ldi_sti is high.

Parameters:
- GAP_CYCLES, 1, idle cycles with no request between pointer read and final access (range 1..3).

Ports:
- clk  in  1  pipeline clock
- reset  in  1  synchronous, active-high reset
- run  in  1  global pipeline advance from freeze logic
- valid  in  1  MEM stage holds a valid instruction
- is_ldi  in  1  MEM instruction is LDI
- is_sti  in  1  MEM instruction is STI
- ea  in  16  effective address of the pointer (lc3b_word)
- sti_data  in  16  source register value for STI
- mem_resp  in  1  data memory response
- mem_rdata  in  16  data memory read data
- mem_read  out  1  read request
- mem_write  out  1  write request
- mem_address  out  16  request address
- mem_wdata  out  16  write data
- mem_byte_enable  out  2  always 2'b11 when requesting
- ldi_sti  out  1  valid & (is_ldi | is_sti); block owns the data port
- ldi_sti_state  out  1  high only in FINAL; pipeline may advance on mem_resp
- ldi_data  out  16  pass-through of mem_rdata, meaningful in FINAL on mem_resp

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Registers:
  - state, encoded as IDLE, GAP, FINAL.
  - ptr, 16 bits.
  - gap_cnt, 2 bits.
- Reset values: state=IDLE, ptr=16'h0000, gap_cnt=0.
- Outputs are combinational from state and inputs. While reset is asserted, all request outputs are 0 and ldi_sti_state=0.
- Instruction priority: is_ldi has priority if both is_ldi and is_sti are set. op_is_write = is_sti & ~is_ldi.
- IDLE (pointer phase):
  - If ldi_sti: mem_read=1, mem_address={ea[15:1],1'b0}.
  - On mem_resp: ptr<=mem_rdata, gap_cnt<=GAP_CYCLES-1, go to GAP.
  - This transition does not depend on run. Freeze stalls anyway, because ldi_sti_state=0.
- GAP:
  - mem_read=0, mem_write=0.
  - Decrement gap_cnt each cycle; go to FINAL when gap_cnt==0.
  - Total GAP dwell is exactly GAP_CYCLES cycles.
- FINAL:
  - mem_address={ptr[15:1],1'b0}.
  - LDI: mem_read=1. STI: mem_write=1, mem_wdata=sti_data.
  - ldi_sti_state=1.
  - Exit to IDLE only when mem_resp & run.
  - If mem_resp arrives while run=0 (e.g. instruction fetch outstanding), stay in FINAL with the request held. The repeated access is idempotent.
- Latency: LDI/STI with single-cycle memory responses occupies MEM for 1 + GAP_CYCLES + 1 cycles (3 at default).
- Back-to-back indirect ops: after FINAL→IDLE, the next instruction's pointer read may issue in the following cycle.
- Non-indirect instructions: ldi_sti=0, state stays IDLE, and the block's request outputs are 0.
- valid drops while in GAP or FINAL (flush): return to IDLE next cycle with no request in that cycle.
- Reset mid-operation: IDLE next cycle. An in-flight access is abandoned; memory ignores a dropped request.
- mem_wdata is 16'h0000 when not writing.

Decomposition:
- Additions to lc3b_types:
  - enum ind_state_t {IND_IDLE, IND_GAP, IND_FINAL}.
  - Reuse lc3b_word for all 16-bit buses.
- Sub-module: none. The ptr register may instantiate the existing generic register module with load = (state==IDLE) & ldi_sti & mem_resp.

Test Plan:
- LDI, ea=16'h3001, memory[3000]=16'h4000, memory[4000]=16'hBEEF, 1-cycle responses:
  - cycle 0: read 3000.
  - cycle 1: no request.
  - cycle 2: read 4000 with ldi_sti_state=1 and ldi_data=BEEF.
  - cycle 3: IDLE.
- STI, ea=16'h3000, pointer=16'h5002, sti_data=16'h1234 → FINAL issues mem_write to 5002 with wdata 1234 and byte_enable 11; exactly one write cycle when run=1.
- LDI with 4-cycle memory latency on both accesses → pointer read held 4 cycles, ldi_sti_state=0 throughout; FINAL held 4 cycles, exit on the 4th.
- FINAL gets mem_resp with run=0 for 2 cycles, then run=1 → stays in FINAL, request held, exits only in the run=1 cycle.
- Reset asserted in GAP → next cycle state=IDLE, no request, ldi_sti_state=0. Next LDI then completes normally.
- ADD followed immediately by LDI, then STI back-to-back → ldi_sti=0 for ADD; each indirect op takes exactly 3 MEM cycles; no extra idle cycle between them.
